spio_rr_merge: RTL

N-to-1 round-robin packet merger: the fan-in counterpart of the 1-to-N spio switch. It collects packets from `NUM_PORTS` rdy/vld input ports and forwards them to a single rdy/vld output, tagging each packet with a one-hot source field. Arbitration is fair round-robin. A 2-entry output skid buffer keeps every `IN_RDY_OUT` independent of `OUT_RDY_IN` while still sustaining one packet per cycle.

---
 rtl/spio_rr_merge.sv | 85 ++++++++
 1 files changed

// File: rtl/spio_rr_merge.sv
// spio_rr_merge: N-to-1 round-robin packet merger with a 2-entry output skid buffer.
module spio_rr_merge #(
  parameter int PKT_BITS  = 72,
  parameter int NUM_PORTS = 2
) (
  input  logic                          CLK_IN,
  input  logic                          RESET_IN,
  input  logic [PKT_BITS*NUM_PORTS-1:0] IN_DATA_IN,
  input  logic [NUM_PORTS-1:0]          IN_VLD_IN,
  output logic [NUM_PORTS-1:0]          IN_RDY_OUT,
  output logic [PKT_BITS-1:0]           OUT_DATA_OUT,
  output logic [NUM_PORTS-1:0]          OUT_SOURCE_OUT,
  output logic                          OUT_VLD_OUT,
  input  logic                          OUT_RDY_IN,
  output logic [NUM_PORTS-1:0]          BLOCKED_INPUTS_OUT
);
  localparam int IW = $clog2(NUM_PORTS);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t                r_state, w_next;
  logic [IW-1:0]         r_last, w_pick, w_idx;
  logic [NUM_PORTS-1:0]  w_sel, r_src, r_skid_src;
  logic [PKT_BITS-1:0]   r_data, r_skid_data, w_in_data;
  logic                  w_found, w_acc, w_xfr;
  int                    w_sum;
  // First valid port after the last accepted one, wrapping modulo NUM_PORTS.
  always_comb begin
    w_sel   = '0;
    w_pick  = r_last;
    w_found = 1'b0;
    w_sum   = 0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      w_sum = int'(r_last) + k;
      w_sum = (w_sum >= NUM_PORTS) ? w_sum - NUM_PORTS : w_sum;
      w_idx = IW'(w_sum);
      if (!w_found && IN_VLD_IN[w_idx]) begin
        w_found      = 1'b1;
        w_pick       = w_idx;
        w_sel[w_idx] = 1'b1;
      end
    end
  end
  assign w_in_data          = IN_DATA_IN[int'(w_pick)*PKT_BITS +: PKT_BITS];
  assign IN_RDY_OUT         = (r_state != FULL && RESET_IN) ? w_sel : '0;
  assign BLOCKED_INPUTS_OUT = IN_VLD_IN & ~IN_RDY_OUT;
  assign w_acc              = |(IN_VLD_IN & IN_RDY_OUT);
  assign OUT_VLD_OUT        = (r_state != EMPTY);
  assign w_xfr              = OUT_VLD_OUT & OUT_RDY_IN;
  assign OUT_DATA_OUT       = r_data;
  assign OUT_SOURCE_OUT     = r_src;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      EMPTY:   w_next = w_acc ? ONE : EMPTY;
      ONE:     w_next = (w_acc && !w_xfr) ? FULL : (!w_acc && w_xfr) ? EMPTY : ONE;
      FULL:    w_next = w_xfr ? ONE : FULL;
      default: w_next = EMPTY;
    endcase
  end
  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      r_state     <= EMPTY;
      r_last      <= IW'(NUM_PORTS - 1);
      r_data      <= '0;
      r_src       <= '0;
      r_skid_data <= '0;
      r_skid_src  <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) r_last <= w_pick;
      // A new packet goes straight to the head when the head is free or draining.
      if (w_acc && (r_state == EMPTY || w_xfr)) begin
        r_data <= w_in_data;
        r_src  <= w_sel;
      end else if (r_state == FULL && w_xfr) begin
        r_data <= r_skid_data;
        r_src  <= r_skid_src;
      end
      if (w_acc && r_state == ONE && !w_xfr) begin
        r_skid_data <= w_in_data;
        r_skid_src  <= w_sel;
      end
    end
  end
endmodule
